// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the repeated-subtraction divider sequencer.
//   state_e      : controller state encoding (binary, 3 bits; codes 6/7 unused)
//   W_DEF        : default datapath width
//   iter_max_of  : iteration cap for a given width (largest W-bit value)
package div_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  // The counter must be able to represent the cap, so the cap is the
  // all-ones value of the counter width; the guard fires before a wrap.
  function automatic int iter_max_of(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if -- control/status bundle between the divider sequencer and
// its surroundings (requester + datapath).
//   master : drives start/abort and the datapath status (rem_ge_div, div_zero),
//            observes strobes, busy/done/err and iter_cnt.
//   slave  : the sequencer itself (mirror directions).
interface div_seq_ctrl_if
  import div_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         start;
  logic         abort;
  logic         rem_ge_div;
  logic         div_zero;
  logic         q_ld;
  logic         q_upd;
  logic         r_ld;
  logic         r_sub;
  logic         d_ld;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] iter_cnt;

  modport master (
    output start, abort, rem_ge_div, div_zero,
    input  q_ld, q_upd, r_ld, r_sub, d_ld, busy, done, err, iter_cnt
  );

  modport slave (
    input  start, abort, rem_ge_div, div_zero,
    output q_ld, q_upd, r_ld, r_sub, d_ld, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/iter_counter.sv
// iter_counter -- W-bit up counter with synchronous clear and enable and a
// terminal flag at MAX. It saturates at MAX instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear (wins over en)
//   en         : count up by one
//   cnt        : current count
//   term       : cnt == MAX
module iter_counter
  import div_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int MAX = iter_max_of(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !term) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign term = (cnt_reg == MAX_V);

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl -- FSM sequencing a repeated-subtraction divider datapath.
// The datapath updates on negedge, so all strobes here are Moore outputs of
// the registered state and are settled half a cycle before use.
//   clk, rst_n : clock (posedge), asynchronous active-low reset
//   bus        : div_seq_ctrl_if slave port
//                in : start, abort, rem_ge_div, div_zero
//                out: q_ld/r_ld/d_ld (LOAD), q_upd/r_sub (SUB), busy,
//                     done (one-cycle pulse), err (sticky), iter_cnt
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int ITER_MAX = iter_max_of(W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  div_seq_ctrl_if.slave        bus
);

  state_e       state_reg;
  state_e       state_next;
  logic         err_reg;
  logic         start_acc;
  logic         cnt_en;
  logic         cnt_term;
  logic [W-1:0] cnt;

  // abort in IDLE is otherwise ignored, but it does suppress a same-cycle start.
  assign start_acc = (state_reg == IDLE) && bus.start && !bus.abort;
  // An aborted SUB cycle must not count, so iter_cnt holds on abort.
  assign cnt_en    = (state_reg == SUB) && !bus.abort;

  iter_counter #(
    .W   (W),
    .MAX (ITER_MAX)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    (cnt_en),
    .cnt   (cnt),
    .term  (cnt_term)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort outranks every other transition.
  always_comb begin
    state_next = IDLE;
    if (bus.abort && state_reg != IDLE) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = start_acc ? LOAD : IDLE;
        LOAD:    state_next = CHECK;
        CHECK: begin
          if (bus.div_zero)                    state_next = ERR;
          else if (bus.rem_ge_div && cnt_term) state_next = ERR;
          else if (bus.rem_ge_div)             state_next = SUB;
          else                                 state_next = DONE;
        end
        SUB:     state_next = CHECK;
        DONE:    state_next = IDLE;
        ERR:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Sticky error: set together with entry into ERR so it is visible in the
  // ERR cycle alongside done, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (start_acc) begin
      err_reg <= 1'b0;
    end else if (state_next == ERR) begin
      err_reg <= 1'b1;
    end
  end

  // Output decode
  always_comb begin
    bus.q_ld  = 1'b0;
    bus.r_ld  = 1'b0;
    bus.d_ld  = 1'b0;
    bus.q_upd = 1'b0;
    bus.r_sub = 1'b0;
    bus.done  = 1'b0;
    bus.busy  = (state_reg != IDLE);
    case (state_reg)
      LOAD: begin
        bus.q_ld = 1'b1;
        bus.r_ld = 1'b1;
        bus.d_ld = 1'b1;
      end
      SUB: begin
        bus.q_upd = 1'b1;
        bus.r_sub = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      ERR:     bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.err      = err_reg;
  assign bus.iter_cnt = cnt;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl -- self-checking bench for div_seq_ctrl. Models the divider
// datapath on negedge, pushes the expected outcome of every started operation
// onto a scoreboard and compares when done is observed.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  div_seq_ctrl_if #(.W(W)) bus ();

  div_seq_ctrl #(
    .W        (W),
    .ITER_MAX (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Datapath model
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic [W-1:0] q_reg    = '0;
  logic [W-1:0] r_reg    = '0;
  logic [W-1:0] d_reg    = '0;
  bit           force_ge = 1'b0;

  assign bus.rem_ge_div = force_ge | (r_reg >= d_reg);
  assign bus.div_zero   = (d_reg == '0);

  typedef struct {
    int cyc;
    int iter;
    int err;
    int q;
    int r;
    bit chk_r;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rel;
  int   sub_seen = 0;
  int   load_seen = 0;
  int   txn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + datapath update
  always @(negedge clk) begin
    if (rst_n) begin
      rel = cyc - start_cyc;
      if (bus.q_ld || bus.r_ld || bus.d_ld) begin
        chk("load_strobes", {bus.q_ld, bus.r_ld, bus.d_ld}, 3'b111);
        chk("load_cycle", rel, 1);
        load_seen <= load_seen + 1;
      end
      if (bus.r_sub || bus.q_upd) begin
        chk("sub_strobes", {bus.r_sub, bus.q_upd}, 2'b11);
        sub_seen <= sub_seen + 1;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", bus.done, 0);
        end else begin
          e = sb.pop_front();
          txn <= txn + 1;
          $display("txn %0d: rel_cycle=%0d iter_cnt=%0d err=%0d q=%0d r=%0d subs=%0d",
                   txn, rel, bus.iter_cnt, bus.err, q_reg, r_reg, sub_seen);
          chk("done_cycle", rel, e.cyc);
          chk("iter_cnt", bus.iter_cnt, e.iter);
          chk("err", bus.err, e.err);
          chk("sub_pulses", sub_seen, e.iter);
          chk("load_pulses", load_seen, 1);
          chk("quotient", q_reg, e.q);
          if (e.chk_r) chk("remainder", r_reg, e.r);
        end
      end
      if (bus.q_ld)  q_reg <= '0;
      if (bus.r_ld)  r_reg <= dividend;
      if (bus.d_ld)  d_reg <= divisor;
      if (bus.q_upd) q_reg <= q_reg + W'(1);
      if (bus.r_sub) r_reg <= r_reg - d_reg;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for 'hold' cycles beginning in relative cycle 0; returns
  // in relative cycle 'hold'.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input bit push, input int ecyc, input int eiter, input int eerr,
                        input int eq, input int er, input bit chk_r);
    exp_t x;
    tick();
    dividend  = a;
    divisor   = b;
    bus.start = 1'b1;
    start_cyc = cyc;
    sub_seen  = 0;
    load_seen = 0;
    if (push) begin
      x = '{ecyc, eiter, eerr, eq, er, chk_r};
      sb.push_back(x);
    end
    for (int i = 0; i < hold; i++) tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (bus.busy || sb.size() != 0); i++) tick();
    chk("idle_after_run", bus.busy, 0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.q_ld, bus.r_ld, bus.d_ld, bus.q_upd, bus.r_sub}, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_iter", bus.iter_cnt, 0);
    #10 rst_n = 1'b1;
    tick();

    // 13 / 4
    launch(8'd13, 8'd4, 1, 1, 9, 3, 0, 3, 1, 1);
    wait_idle(50);

    // 3 / 7: no SUB cycles
    launch(8'd3, 8'd7, 1, 1, 3, 0, 0, 0, 3, 1);
    wait_idle(50);

    // Divide by zero, then err must stick until the next accepted start
    launch(8'd5, 8'd0, 1, 1, 3, 0, 1, 0, 5, 1);
    wait_idle(50);
    tick(); tick(); tick();
    chk("err_sticky", bus.err, 1);
    launch(8'd3, 8'd7, 1, 1, 3, 0, 0, 0, 3, 1);
    chk("err_cleared_after_start", bus.err, 0);
    wait_idle(50);

    // Iteration cap
    force_ge = 1'b1;
    launch(8'd0, 8'd1, 1, 1, 2 * 255 + 3, 255, 1, 255, 0, 0);
    wait_idle(600);
    force_ge = 1'b0;
    chk("err_after_overflow", bus.err, 1);

    // start held high while busy: exactly one LOAD per run
    launch(8'd13, 8'd4, 5, 1, 9, 3, 0, 3, 1, 1);
    wait_idle(50);

    // abort beats a same-cycle start in IDLE
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_beats_start", bus.busy, 0);

    // abort in cycle 4 of a 13/4 run, restart in cycle 6
    launch(8'd13, 8'd4, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_idle_busy", bus.busy, 0);
    chk("abort_iter_hold", bus.iter_cnt, 1);
    chk("abort_err", bus.err, 0);
    chk("abort_no_done", bus.done, 0);
    launch(8'd13, 8'd4, 1, 1, 9, 3, 0, 3, 1, 1);
    wait_idle(50);

    // Async reset in the middle of the second SUB cycle
    launch(8'd13, 8'd4, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    chk("pre_reset_sub", bus.r_sub, 1);
    chk("pre_reset_iter", bus.iter_cnt, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", bus.busy, 0);
    chk("mid_reset_strobes", {bus.q_ld, bus.r_ld, bus.d_ld, bus.q_upd, bus.r_sub}, 0);
    chk("mid_reset_iter", bus.iter_cnt, 0);
    chk("mid_reset_done", bus.done, 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_busy", bus.busy, 0);

    // Normal operation after reset
    launch(8'd13, 8'd4, 1, 1, 9, 3, 0, 3, 1, 1);
    wait_idle(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- FSM controller that sequences the repeated-subtraction divider datapath: the quotient register (load/increment), the remainder register (load/subtract) and the divisor register (load).
- Accepts a start request, runs CHECK/SUB iterations until remainder < divisor, then reports done or error.
- Runs on posedge clk. Datapath registers update on negedge, so every control strobe is stable half a cycle before it is used.

Parameters:
- W, 8, datapath width (dividend, divisor, quotient, iteration counter).
- ITER_MAX, 2**W-1, iteration cap; reaching it with rem_ge_div still high is an error.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous abort; forces IDLE from any non-IDLE state.
- rem_ge_div  in  1  datapath compare status, remainder >= divisor.
- div_zero  in  1  datapath status, divisor == 0.
- q_ld  out  1  quotient register load (datapath drives its din to 0).
- q_upd  out  1  quotient increment.
- r_ld  out  1  remainder register load with dividend.
- r_sub  out  1  remainder <= remainder - divisor.
- d_ld  out  1  divisor register load.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag (divide-by-zero or iteration overflow).
- iter_cnt  out  W  number of SUB cycles executed in the current operation.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, iter_cnt=0, err=0, all strobes 0, busy=0, done=0.
- All strobes are Moore outputs decoded from the registered state. No strobe is active in two different states.
- IDLE: when start=1, go to LOAD, clear err, clear iter_cnt.
- LOAD: q_ld=r_ld=d_ld=1 for exactly one cycle, then CHECK.
- CHECK: no strobes. Transition priority:
  - div_zero=1 -> ERR;
  - else rem_ge_div=1 and iter_cnt==ITER_MAX -> ERR;
  - else rem_ge_div=1 -> SUB;
  - else -> DONE.
- SUB: r_sub=q_upd=1 for one cycle; iter_cnt increments; then CHECK.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err set to 1, done=1 for one cycle, then IDLE. err stays high until the next start is accepted.
- Latency: with start sampled in cycle 0, done is high in cycle 2q+3, where q is the final quotient. Divide-by-zero: done and err in cycle 3.
- Throughput: a new start is accepted no earlier than the cycle after done. start is ignored while busy=1.
- abort=1 in any non-IDLE state: next state is IDLE, no done pulse, err unchanged, iter_cnt holds its value. abort has priority over all other transitions, including DONE/ERR. abort in IDLE is ignored, and it beats a same-cycle start.
- Async reset mid-operation: immediate return to IDLE with reset values; datapath contents are don't-care.
- iter_cnt never wraps; the ITER_MAX guard fires first.
- State encoding: binary, 3 bits. Unused encodings go to IDLE.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, LOAD, CHECK, SUB, DONE, ERR);
  - W default;
  - ITER_MAX derivation.
- Natural sub-module: iter_counter (W-bit counter with clear, enable, terminal flag at ITER_MAX), reusable for other sequencers. The FSM and output decode stay in div_seq_ctrl.

Test Plan:
- Reset mid-SUB (rst_n low for 1 ns between edges) -> busy, strobes and iter_cnt drop to 0 immediately; state IDLE.
- Dividend 13, divisor 4 (bench models datapath): start in cycle 0 -> LOAD in cycle 1, three SUB pulses, done in cycle 9, iter_cnt=3, err=0, datapath quotient=3, remainder=1.
- Dividend 3, divisor 7 -> zero SUB cycles; done in cycle 3, iter_cnt=0, err=0.
- Divisor 0 -> ERR; done and err in cycle 3, err stays 1 until the next start, cleared in the cycle after that start is accepted.
- rem_ge_div forced high permanently, divisor 1 -> 255 SUB pulses, then ERR; done and err at cycle 2*255+3, iter_cnt=255.
- abort asserted in cycle 4 of the 13/4 run -> IDLE in cycle 5, no done pulse; start in cycle 6 is accepted and the run completes normally. start held high while busy -> no re-entry into LOAD.
